mac_vec_sequencer: RTL and testbench

- Initiator-side controller for the mac2 multiply-accumulate unit in the BDD accelerator datapath.
- Accepts attribute/coefficient pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues the pairs to the MAC one per cycle, clears the MAC at the start of each vector, and waits out the MAC latency.
- Returns the captured 32-bit dot product and the element count on a valid/ready result port.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_op_fifo.sv | 50 +++++
 rtl/mac_vec_sequencer.sv | 126 ++++++++++++
 tb/tb_mac_vec_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and defaults for the mac2 vector sequencer
// Contents: operand/accumulator width defaults, sequencer state enum,
// operand FIFO entry struct.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] attr;
    logic [DATA_W-1:0] coeff;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/mac_op_fifo.sv
// rtl/mac_op_fifo.sv - synchronous operand FIFO for the mac2 sequencer
// Ports: clk, rst_in (async active-low), push/push_data (write side),
// pop/pop_data (read side, head shown combinationally), full, empty.
// Push while full and pop while empty are ignored; no pass-through.
module mac_op_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  // One extra pointer bit separates full from empty when indices match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mac_vec_sequencer.sv
// rtl/mac_vec_sequencer.sv - initiator-side vector controller for the mac2 MAC
// Ports: clk, rst_in (async active-low); operand stream in_valid/in_ready/
// in_attr/in_coeff/in_last; MAC side mac_a/mac_b/mac_clr (registered) and
// mac_acc; result stream res_valid/res_ready/res_data/res_count.
module mac_vec_sequencer #(
  parameter int DATA_W     = mac_pkg::DATA_W,
  parameter int ACC_W      = mac_pkg::ACC_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAC_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_attr,
  input  logic [DATA_W-1:0] in_coeff,
  input  logic              in_last,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [7:0]        res_count
);

  import mac_pkg::*;

  localparam int DW = $clog2(MAC_LAT + 2);

  state_t            state;
  state_t            state_nxt;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rdy_en;
  logic              drain_done;
  logic [DW-1:0]     drain_cnt;
  logic [7:0]        elem_cnt;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic              clr_nxt;

  // in_ready is held low in reset and rises on the first edge after release.
  assign in_ready   = rdy_en && !full;
  assign push       = in_valid && in_ready;
  assign push_entry = '{attr: in_attr, coeff: in_coeff, last: in_last};
  // The counter hits 0 on the edge where it was 1: that edge latches mac_acc.
  assign drain_done = (state == DRAIN) && (drain_cnt == DW'(1));

  mac_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN:     if (pop && head.last) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered MAC outputs; zeros whenever no pair issues.
  always_comb begin
    pop     = (state == RUN) && !empty;
    a_nxt   = pop ? head.attr  : '0;
    b_nxt   = pop ? head.coeff : '0;
    clr_nxt = (state == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      mac_a     <= '0;
      mac_b     <= '0;
      mac_clr   <= 1'b1;
      rdy_en    <= 1'b0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
    end else begin
      mac_a   <= a_nxt;
      mac_b   <= b_nxt;
      mac_clr <= clr_nxt;
      rdy_en  <= 1'b1;

      if (state == CLEAR)                  elem_cnt <= '0;
      else if (pop && elem_cnt != 8'hFF)   elem_cnt <= elem_cnt + 8'd1;

      if (pop && head.last)                drain_cnt <= DW'(MAC_LAT + 1);
      else if (state == DRAIN)             drain_cnt <= drain_cnt - DW'(1);

      if (drain_done) begin
        res_valid <= 1'b1;
        res_data  <= mac_acc;
        res_count <= elem_cnt;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_sequencer.sv
// tb/tb_mac_vec_sequencer.sv - self-checking bench for mac_vec_sequencer
module tb_mac_vec_sequencer;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAC_LAT    = 1;

  logic              clk = 1'b0;
  logic              rst_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_attr;
  logic [DATA_W-1:0] in_coeff;
  logic              in_last;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_clr;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [7:0]        res_count;

  always #5 clk = ~clk;

  mac_vec_sequencer #(
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_attr   (in_attr),
    .in_coeff  (in_coeff),
    .in_last   (in_last),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clr   (mac_clr),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count)
  );

  // mac2 model: single-cycle multiply-accumulate with synchronous clear.
  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else         mac_acc <= mac_acc + 32'(mac_a) * 32'(mac_b);
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_data [0:31];
  logic [7:0]  got_cnt  [0:31];
  int          got_n    = 0;
  int          clr_rise = 0;
  logic        clr_prev = 1'b1;

  // Result capture and mac_clr pulse counting, between clock edges.
  always @(negedge clk) begin
    #2;
    if (res_valid && res_ready && got_n < 32) begin
      got_data[got_n] = res_data;
      got_cnt[got_n]  = res_count;
      got_n++;
    end
    if (rst_in && mac_clr && !clr_prev) clr_rise++;
    clr_prev = mac_clr;
  end

  logic [31:0] exp_data [$];
  logic [7:0]  exp_cnt  [$];
  int          rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic l);
    int n;
    in_valid = 1'b1;
    in_attr  = a;
    in_coeff = b;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_vec(input logic [31:0] d, input logic [7:0] c);
    exp_data.push_back(d);
    exp_cnt.push_back(c);
  endtask

  task automatic check_next(input string tag);
    int n;
    logic [31:0] ed;
    logic [7:0]  ec;
    n = 0;
    while (got_n <= rd && n < 500) begin
      @(negedge clk);
      n++;
    end
    ed = exp_data.pop_front();
    ec = exp_cnt.pop_front();
    if (got_n <= rd) begin
      chk({tag, "_timeout"}, 32'(got_n), 32'(rd + 1));
    end else begin
      chk({tag, "_data"}, got_data[rd], ed);
      chk({tag, "_count"}, 32'(got_cnt[rd]), 32'(ec));
      rd++;
    end
  endtask

  task automatic wait_mac(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (!(mac_a == a && mac_b == b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(mac_a == a && mac_b == b), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    int base;
    logic acc;

    rst_in    = 1'b0;
    in_valid  = 1'b0;
    in_attr   = '0;
    in_coeff  = '0;
    in_last   = 1'b0;
    res_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd1);
    chk("rst_mac_ab", {mac_a, mac_b}, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    rst_in = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Vector 1 plus latency from the last pop to res_valid.
    base = clr_rise;
    send(49, 10, 0); send(30, 10, 0); send(14, 0, 0); send(47, 10, 0); send(32, 10, 1);
    expect_vec(32'd1580, 8'd5);
    wait_mac("t1_last_issue", 16'd32, 16'd10);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", 32'(n), 32'(MAC_LAT + 1));
    check_next("t1");

    // Vector 2 right behind it.
    send(49, 10, 0); send(30, 10, 0); send(13, 10, 1);
    expect_vec(32'd920, 8'd3);
    check_next("t2");
    chk("clr_pulses", 32'(clr_rise - base), 32'd2);

    // Bubbles between pairs must issue zeros.
    send(7, 3, 0);
    expect_vec(32'd41, 8'd2);
    wait_mac("bub_first_issue", 16'd7, 16'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bubble_zero", {mac_a, mac_b}, 32'd0);
    end
    send(5, 4, 1);
    check_next("bubble");

    // Result backpressure while the FIFO fills.
    res_ready = 1'b0;
    send(1, 2, 0); send(3, 4, 1);
    expect_vec(32'd14, 8'd2);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    expect_vec(32'd21, 8'd6);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) begin
        in_valid = 1'b1;
        in_attr  = 16'(k + 1);
        in_coeff = 16'd1;
        in_last  = (k == 5);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_pushes", 32'(k), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_res_stable", res_data, 32'd14);
    chk("bp_no_handshake", 32'(got_n), 32'(rd));
    res_ready = 1'b1;
    for (int j = k; j < 6; j++) send(16'(j + 1), 16'd1, (j == 5));
    check_next("bp_a");
    check_next("bp_b");

    // Reset in the middle of a vector.
    send(10, 10, 0); send(20, 20, 0); send(30, 30, 0);
    wait_mac("mid_second_issue", 16'd20, 16'd20);
    rst_in = 1'b0;
    #1;
    chk("mid_mac_clr", 32'(mac_clr), 32'd1);
    chk("mid_mac_ab", {mac_a, mac_b}, 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_res_data", res_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_result", 32'(got_n), 32'(rd));

    // Single-pair vector at full scale.
    send(16'hFFFF, 16'hFFFF, 1);
    expect_vec(32'hFFFE0001, 8'd1);
    check_next("single");

    repeat (5) @(negedge clk);
    chk("total_results", 32'(got_n), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
